// File: rtl/mips_dbg_pkg.sv
// mips_dbg_pkg: shared definitions for the mips run/debug sequencer.
//   - run_state_t   : sequencer FSM states
//   - CMD_*         : cmd_op encodings (HALT, RUN, STEP, RUN_N)
//   - CAUSE_*       : stop_cause encodings
//   - HALT_OP_DEFAULT : opcode in im_out[15:12] that acts as a halt instruction
//   - is_active()   : true for states that may drive work high
package mips_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_RUN_N = 2'd2,
    ST_STEP  = 2'd3
  } run_state_t;

  localparam logic [1:0] CMD_HALT  = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_RUN_N = 2'b11;

  localparam logic [2:0] CAUSE_NONE       = 3'd0;
  localparam logic [2:0] CAUSE_CMD        = 3'd1;
  localparam logic [2:0] CAUSE_COUNT      = 3'd2;
  localparam logic [2:0] CAUSE_BREAK      = 3'd3;
  localparam logic [2:0] CAUSE_HALT_INSTR = 3'd4;

  localparam logic [3:0] HALT_OP_DEFAULT = 4'hF;

  function automatic logic is_active(input run_state_t s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/mips_run_ctrl_if.sv
// mips_run_ctrl_if: command channel into the run/debug sequencer.
//   cmd_valid : command present
//   cmd_ready : command accepted on a posedge where cmd_valid & cmd_ready
//   cmd_op    : 00 HALT, 01 RUN, 10 STEP, 11 RUN_N
//   cmd_arg   : cycle count for RUN_N
// Handshake: a command transfers on a rising clk edge where both cmd_valid
// and cmd_ready are high; cmd_op/cmd_arg must be stable while cmd_valid is
// high. cmd_ready may depend combinationally on cmd_op (HALT is always
// accepted), so the master must not make cmd_op depend on cmd_ready.
interface mips_run_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_arg;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_arg,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_arg,
    output cmd_ready
  );
endinterface

// File: rtl/mips_stop_detect.sv
// mips_stop_detect: combinational stop-condition evaluator.
// Inputs : state, first, cmd_valid, cmd_op, pc, bp_en, bp_addr, im_out
// Outputs: stop  - an active state must end this cycle without doing work
//          cause - stop_cause code for that stop
// Priority: HALT command, then halt instruction, then breakpoint. In STEP
// only the HALT command counts; the step always executes otherwise.
module mips_stop_detect
  import mips_dbg_pkg::*;
#(
  parameter int         PC_W    = 8,
  parameter logic [3:0] HALT_OP = HALT_OP_DEFAULT
) (
  input  run_state_t       state,
  input  logic             first,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [PC_W-1:0]  pc,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [15:0]      im_out,
  output logic             stop,
  output logic [2:0]       cause
);

  logic hcmd;
  logic hins;
  logic brk;
  logic unused_im;

  // Only the opcode field matters here.
  assign unused_im = ^im_out[11:0];

  // first masks hins/brk so a resume steps past the instruction that stopped us.
  assign hcmd = cmd_valid && (cmd_op == CMD_HALT);
  assign hins = !first && (im_out[15:12] == HALT_OP);
  assign brk  = !first && bp_en && (pc == bp_addr);

  always_comb begin
    stop  = 1'b0;
    cause = CAUSE_NONE;
    case (state)
      ST_RUN, ST_RUN_N: begin
        if (hcmd) begin
          stop  = 1'b1;
          cause = CAUSE_CMD;
        end else if (hins) begin
          stop  = 1'b1;
          cause = CAUSE_HALT_INSTR;
        end else if (brk) begin
          stop  = 1'b1;
          cause = CAUSE_BREAK;
        end
      end
      ST_STEP: begin
        if (hcmd) begin
          stop  = 1'b1;
          cause = CAUSE_CMD;
        end
      end
      default: begin
        stop  = 1'b0;
        cause = CAUSE_NONE;
      end
    endcase
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: run/debug sequencer producing the work enable for mips.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   cmd         : command channel (mips_run_ctrl_if.slave)
//   bp_en       : breakpoint enable
//   bp_addr     : breakpoint PC
//   pc, im_out  : observed datapath PC and fetched instruction
//   work        : datapath enable (combinational, drops as soon as rst rises)
//   busy        : sequencer not idle
//   done        : one-cycle pulse after returning to idle from an active state
//   stop_cause  : why the last run ended (held until the next RUN/STEP/RUN_N)
//   cycles      : number of cycles with work=1, wraps, cleared only by reset
//   state_dbg   : current FSM state
module mips_run_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int         PC_W    = 8,
  parameter int         CNT_W   = 16,
  parameter int         CYC_W   = 32,
  parameter logic [3:0] HALT_OP = HALT_OP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  mips_run_ctrl_if.slave    cmd,
  input  logic              bp_en,
  input  logic [PC_W-1:0]   bp_addr,
  input  logic [PC_W-1:0]   pc,
  input  logic [15:0]       im_out,
  output logic              work,
  output logic              busy,
  output logic              done,
  output logic [2:0]        stop_cause,
  output logic [CYC_W-1:0]  cycles,
  output run_state_t        state_dbg
);

  run_state_t       state, state_n;
  logic             first, first_n;
  logic [CNT_W-1:0] remaining, remaining_n;
  logic [2:0]       cause_n;
  logic             done_n;
  logic             det_stop;
  logic [2:0]       det_cause;

  mips_stop_detect #(
    .PC_W    (PC_W),
    .HALT_OP (HALT_OP)
  ) u_stop_detect (
    .state     (state),
    .first     (first),
    .cmd_valid (cmd.cmd_valid),
    .cmd_op    (cmd.cmd_op),
    .pc        (pc),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .im_out    (im_out),
    .stop      (det_stop),
    .cause     (det_cause)
  );

  // HALT is always accepted so it can interrupt an active run.
  assign cmd.cmd_ready = (state == ST_IDLE) || (cmd.cmd_op == CMD_HALT);
  assign busy          = is_active(state);
  assign state_dbg     = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      first      <= 1'b0;
      remaining  <= '0;
      stop_cause <= CAUSE_NONE;
      done       <= 1'b0;
      cycles     <= '0;
    end else begin
      state      <= state_n;
      first      <= first_n;
      remaining  <= remaining_n;
      stop_cause <= cause_n;
      done       <= done_n;
      cycles     <= cycles + {{(CYC_W-1){1'b0}}, work};
    end
  end

  always_comb begin
    state_n     = state;
    first_n     = first;
    remaining_n = remaining;
    cause_n     = stop_cause;
    done_n      = 1'b0;
    work        = 1'b0;
    case (state)
      ST_IDLE: begin
        // HALT in idle is accepted (cmd_ready=1) but changes nothing.
        if (cmd.cmd_valid && (cmd.cmd_op != CMD_HALT)) begin
          first_n = 1'b1;
          cause_n = CAUSE_NONE;
          case (cmd.cmd_op)
            CMD_RUN:  state_n = ST_RUN;
            CMD_STEP: state_n = ST_STEP;
            CMD_RUN_N: begin
              state_n     = ST_RUN_N;
              remaining_n = cmd.cmd_arg;
            end
            default: state_n = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        first_n = 1'b0;
        if (det_stop) begin
          state_n = ST_IDLE;
          cause_n = det_cause;
          done_n  = 1'b1;
        end else begin
          work = 1'b1;
        end
      end
      ST_RUN_N: begin
        first_n = 1'b0;
        if (det_stop) begin
          state_n = ST_IDLE;
          cause_n = det_cause;
          done_n  = 1'b1;
        end else if (remaining == '0) begin
          // RUN_N with a zero argument: finish without doing any work.
          state_n = ST_IDLE;
          cause_n = CAUSE_COUNT;
          done_n  = 1'b1;
        end else begin
          work        = 1'b1;
          remaining_n = remaining - 1'b1;
          if (remaining == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_n = ST_IDLE;
            cause_n = CAUSE_COUNT;
            done_n  = 1'b1;
          end
        end
      end
      ST_STEP: begin
        first_n = 1'b0;
        state_n = ST_IDLE;
        done_n  = 1'b1;
        if (det_stop) begin
          cause_n = det_cause;
        end else begin
          work    = 1'b1;
          cause_n = CAUSE_COUNT;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb_mips_run_ctrl: directed bench for mips_run_ctrl. A tiny datapath model
// advances pc on every work cycle and fetches im_out from a bench-owned
// instruction table; expected values below are worked out by hand.
module tb_mips_run_ctrl;
  import mips_dbg_pkg::*;

  localparam int PC_W  = 8;
  localparam int CNT_W = 16;
  localparam int CYC_W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT hookup ----------------
  mips_run_ctrl_if #(.CNT_W(CNT_W)) cmd_if ();

  logic              bp_en;
  logic [PC_W-1:0]   bp_addr;
  logic [PC_W-1:0]   pc = '0;
  logic [15:0]       im_out;
  logic              work;
  logic              busy;
  logic              done;
  logic [2:0]        stop_cause;
  logic [CYC_W-1:0]  cycles;
  run_state_t        state_dbg;

  mips_run_ctrl #(
    .PC_W    (PC_W),
    .CNT_W   (CNT_W),
    .CYC_W   (CYC_W),
    .HALT_OP (4'hF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd_if.slave),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc),
    .im_out     (im_out),
    .work       (work),
    .busy       (busy),
    .done       (done),
    .stop_cause (stop_cause),
    .cycles     (cycles),
    .state_dbg  (state_dbg)
  );

  // ---------------- datapath model ----------------
  logic        pc_clr;
  logic [15:0] imem [0:255];

  assign im_out = imem[pc];

  always @(posedge clk) begin
    if (pc_clr) pc <= '0;
    else if (work) pc <= pc + 1'b1;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Every step lands 1 time unit after a falling edge: inputs are driven
  // there and outputs sampled after a further #1.
  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  // Present a command for one cycle; returns in the cycle after acceptance.
  task automatic send_cmd(input logic [1:0] op, input logic [CNT_W-1:0] arg);
    next_cyc();
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_arg   = arg;
    #1;
    next_cyc();
    cmd_if.cmd_valid = 1'b0;
    #1;
  endtask

  task automatic clear_pc();
    next_cyc();
    pc_clr = 1'b1;
    next_cyc();
    pc_clr = 1'b0;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = CMD_HALT;
    cmd_if.cmd_arg   = '0;
    bp_en   = 1'b0;
    bp_addr = '0;
    pc_clr  = 1'b1;

    // Reset state
    next_cyc();
    next_cyc();
    check_eq("rst_work",  work,       0);
    check_eq("rst_busy",  busy,       0);
    check_eq("rst_done",  done,       0);
    check_eq("rst_cause", stop_cause, 0);
    check_eq("rst_cyc",   cycles,     0);
    check_eq("rst_state", state_dbg,  ST_IDLE);
    next_cyc();
    rst    = 1'b0;
    pc_clr = 1'b0;
    #1;

    // STEP x3: isolated single work cycles, done pulse after each
    for (int s = 0; s < 3; s++) begin
      send_cmd(CMD_STEP, '0);
      check_eq("step_work", work, 1);
      check_eq("step_busy", busy, 1);
      next_cyc();
      check_eq("step_work_off", work,       0);
      check_eq("step_done",     done,       1);
      check_eq("step_cause",    stop_cause, CAUSE_COUNT);
      check_eq("step_idle",     busy,       0);
      next_cyc();
      check_eq("step_done_off", done, 0);
    end
    check_eq("step_cycles", cycles, 3);

    // RUN_N 5: five consecutive work cycles
    send_cmd(CMD_RUN_N, 16'd5);
    for (int i = 0; i < 5; i++) begin
      check_eq("runn5_work", work, 1);
      next_cyc();
    end
    check_eq("runn5_work_off", work,       0);
    check_eq("runn5_done",     done,       1);
    check_eq("runn5_cause",    stop_cause, CAUSE_COUNT);
    check_eq("runn5_cycles",   cycles,     8);

    // RUN_N 0: no work, done next cycle
    send_cmd(CMD_RUN_N, 16'd0);
    check_eq("runn0_work", work, 0);
    check_eq("runn0_busy", busy, 1);
    next_cyc();
    check_eq("runn0_done",   done,       1);
    check_eq("runn0_cause",  stop_cause, CAUSE_COUNT);
    check_eq("runn0_cycles", cycles,     8);

    // RUN into breakpoint at pc 6
    clear_pc();
    bp_en   = 1'b1;
    bp_addr = 8'h06;
    send_cmd(CMD_RUN, '0);
    for (int i = 0; i < 6; i++) begin
      check_eq("bp_run_work", work, 1);
      next_cyc();
    end
    check_eq("bp_hit_work", work, 0);
    check_eq("bp_hit_busy", busy, 1);
    next_cyc();
    check_eq("bp_done",   done,       1);
    check_eq("bp_cause",  stop_cause, CAUSE_BREAK);
    check_eq("bp_cycles", cycles,     14);

    // Resume from the breakpoint; stop with a HALT command two cycles later
    send_cmd(CMD_RUN, '0);
    check_eq("bp_resume_work", work, 1);
    next_cyc();
    check_eq("bp_resume_work2", work, 1);
    next_cyc();
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = CMD_HALT;
    #1;
    check_eq("halt_ready", cmd_if.cmd_ready, 1);
    check_eq("halt_work",  work,             0);
    next_cyc();
    cmd_if.cmd_valid = 1'b0;
    #1;
    check_eq("halt_done",   done,       1);
    check_eq("halt_cause",  stop_cause, CAUSE_CMD);
    check_eq("halt_cycles", cycles,     16);

    // Halt instruction on the 4th active cycle (pc 3)
    bp_en   = 1'b0;
    imem[3] = 16'hF000;
    clear_pc();
    send_cmd(CMD_RUN, '0);
    for (int i = 0; i < 3; i++) begin
      check_eq("hins_run_work", work, 1);
      next_cyc();
    end
    check_eq("hins_work", work, 0);
    next_cyc();
    check_eq("hins_done",   done,       1);
    check_eq("hins_cause",  stop_cause, CAUSE_HALT_INSTR);
    check_eq("hins_cycles", cycles,     19);

    // HALT while idle: accepted, no effect
    next_cyc();
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = CMD_HALT;
    #1;
    check_eq("idle_halt_ready", cmd_if.cmd_ready, 1);
    next_cyc();
    cmd_if.cmd_valid = 1'b0;
    #1;
    check_eq("idle_halt_done",  done,       0);
    check_eq("idle_halt_busy",  busy,       0);
    check_eq("idle_halt_cause", stop_cause, CAUSE_HALT_INSTR);

    // Priority: HALT cmd + halt instr + breakpoint all at pc 5
    imem[5] = 16'hF000;
    bp_en   = 1'b1;
    bp_addr = 8'h05;
    send_cmd(CMD_RUN, '0);
    check_eq("prio_resume_work", work, 1);
    next_cyc();
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = CMD_RUN;
    #1;
    check_eq("busy_run_ready", cmd_if.cmd_ready, 0);
    check_eq("busy_run_work",  work,             1);
    next_cyc();
    cmd_if.cmd_op = CMD_HALT;
    #1;
    check_eq("prio_ready", cmd_if.cmd_ready, 1);
    check_eq("prio_work",  work,             0);
    next_cyc();
    cmd_if.cmd_valid = 1'b0;
    #1;
    check_eq("prio_done",   done,       1);
    check_eq("prio_cause",  stop_cause, CAUSE_CMD);
    check_eq("prio_cycles", cycles,     21);

    // HALT in the STEP cycle cancels the step
    bp_en = 1'b0;
    next_cyc();
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = CMD_STEP;
    #1;
    next_cyc();
    cmd_if.cmd_op = CMD_HALT;
    #1;
    check_eq("stepc_state", state_dbg, ST_STEP);
    check_eq("stepc_work",  work,      0);
    next_cyc();
    cmd_if.cmd_valid = 1'b0;
    #1;
    check_eq("stepc_done",   done,       1);
    check_eq("stepc_cause",  stop_cause, CAUSE_CMD);
    check_eq("stepc_cycles", cycles,     21);

    // Reset in the middle of RUN_N (remaining = 3)
    imem[3] = 16'h0000;
    imem[5] = 16'h0000;
    send_cmd(CMD_RUN_N, 16'd5);
    next_cyc();
    next_cyc();
    check_eq("mid_work",   work,   1);
    check_eq("mid_cycles", cycles, 23);
    rst = 1'b1;
    #1;
    check_eq("arst_work",  work,       0);
    check_eq("arst_busy",  busy,       0);
    check_eq("arst_cyc",   cycles,     0);
    check_eq("arst_cause", stop_cause, 0);
    check_eq("arst_done",  done,       0);
    next_cyc();
    check_eq("arst_done_hold", done, 0);
    rst = 1'b0;
    next_cyc();
    check_eq("arst_done_after", done, 0);
    check_eq("arst_idle_after", busy, 0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Time bound on the whole run
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
